// File: rtl/cw_datapath_pkg.sv
// Shared definitions for the control-word datapath: field positions, function
// select encoding and default sizes.
package cw_datapath_pkg;

    localparam int DW_DEF        = 32;
    localparam int NREG_DEF      = 32;
    localparam int MEM_DEPTH_DEF = 256;
    localparam int CW_W          = 55;

    localparam int DA_MSB    = 54;
    localparam int DA_LSB    = 50;
    localparam int AA_MSB    = 49;
    localparam int AA_LSB    = 45;
    localparam int BA_MSB    = 44;
    localparam int BA_LSB    = 40;
    localparam int MB_BIT    = 39;
    localparam int FS_MSB    = 38;
    localparam int FS_LSB    = 35;
    localparam int MD_BIT    = 34;
    localparam int RW_BIT    = 33;
    localparam int MW_BIT    = 32;
    localparam int CONST_MSB = 31;
    localparam int CONST_LSB = 0;

    typedef enum logic [3:0] {
        FS_TSA   = 4'b0000,
        FS_INC   = 4'b0001,
        FS_ADD   = 4'b0010,
        FS_ADDC  = 4'b0011,
        FS_ADDNB = 4'b0100,
        FS_SUB   = 4'b0101,
        FS_DEC   = 4'b0110,
        FS_TSA2  = 4'b0111,
        FS_AND   = 4'b1000,
        FS_OR    = 4'b1001,
        FS_XOR   = 4'b1010,
        FS_NOT   = 4'b1011,
        FS_TSB   = 4'b1100,
        FS_LSR   = 4'b1101,
        FS_LSL   = 4'b1110,
        FS_ASR   = 4'b1111
    } fs_e;

endpackage

// File: rtl/cw_function_unit.sv
// Combinational function unit: one shared adder for the arithmetic codes,
// plus logic and single-bit shift operations, with V/C/N/Z status.
module cw_function_unit
    import cw_datapath_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  fs_e           fs,
    output logic [DW-1:0] f,
    output logic          flag_v,
    output logic          flag_c,
    output logic          flag_n,
    output logic          flag_z
);

    logic [DW-1:0] y;
    logic          cin;
    logic [DW:0]   sum;

    always_comb begin
        y   = '0;
        cin = 1'b0;
        case (fs)
            FS_INC:   cin = 1'b1;
            FS_ADD:   y   = b;
            FS_ADDC:  begin y = b;  cin = 1'b1; end
            FS_ADDNB: y   = ~b;
            FS_SUB:   begin y = ~b; cin = 1'b1; end
            FS_DEC:   y   = '1;
            default:  ;
        endcase
        sum = {1'b0, a} + {1'b0, y} + {{DW{1'b0}}, cin};
    end

    always_comb begin
        f      = '0;
        flag_c = 1'b0;
        flag_v = 1'b0;
        case (fs)
            FS_TSA, FS_INC, FS_ADD, FS_ADDC,
            FS_ADDNB, FS_SUB, FS_DEC, FS_TSA2: begin
                f      = sum[DW-1:0];
                flag_c = sum[DW];
                flag_v = (a[DW-1] == y[DW-1]) && (sum[DW-1] != a[DW-1]);
            end
            FS_AND: f = a & b;
            FS_OR:  f = a | b;
            FS_XOR: f = a ^ b;
            FS_NOT: f = ~a;
            FS_TSB: f = b;
            // Shift carry is the bit that falls off the end.
            FS_LSR: begin f = {1'b0, b[DW-1:1]};     flag_c = b[0];    end
            FS_LSL: begin f = {b[DW-2:0], 1'b0};     flag_c = b[DW-1]; end
            FS_ASR: begin f = {b[DW-1], b[DW-1:1]};  flag_c = b[0];    end
            default: ;
        endcase
        flag_n = f[DW-1];
        flag_z = (f == '0);
    end

endmodule

// File: rtl/cw_datapath.sv
// Single-cycle microprogrammed datapath: register file, B mux, function unit,
// data memory and writeback mux, all steered by one control word per clock.
module cw_datapath
    import cw_datapath_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int NREG      = NREG_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CW_W-1:0] control_word,
    output logic [DW-1:0]   bus_a,
    output logic [DW-1:0]   bus_b,
    output logic [DW-1:0]   bus_d,
    output logic            flag_v,
    output logic            flag_c,
    output logic            flag_n,
    output logic            flag_z
);

    localparam int RAW = $clog2(NREG);
    localparam int MAW = $clog2(MEM_DEPTH);

    logic [RAW-1:0] da, aa, ba;
    logic           mb, md, rw, mw;
    fs_e            fs;
    logic [DW-1:0]  cnst;
    logic [DW-1:0]  f;
    logic [MAW-1:0] mem_addr;

    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];
    logic [DW-1:0] mem    [MEM_DEPTH];

    always_comb begin
        da   = control_word[DA_MSB:DA_LSB];
        aa   = control_word[AA_MSB:AA_LSB];
        ba   = control_word[BA_MSB:BA_LSB];
        mb   = control_word[MB_BIT];
        fs   = fs_e'(control_word[FS_MSB:FS_LSB]);
        md   = control_word[MD_BIT];
        rw   = control_word[RW_BIT];
        mw   = control_word[MW_BIT];
        cnst = control_word[CONST_MSB:CONST_LSB];
    end

    // Address uses only the low bus_a bits, so it wraps over the memory depth.
    always_comb begin
        bus_a    = regs_q[aa];
        bus_b    = mb ? cnst : regs_q[ba];
        mem_addr = bus_a[MAW-1:0];
        bus_d    = md ? mem[mem_addr] : f;
    end

    cw_function_unit #(.DW(DW)) u_fu (
        .a      (bus_a),
        .b      (bus_b),
        .fs     (fs),
        .f      (f),
        .flag_v (flag_v),
        .flag_c (flag_c),
        .flag_n (flag_n),
        .flag_z (flag_z)
    );

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = rst ? '0 : regs_q[i];
        end
        if (!rst && rw) begin
            regs_d[da] = bus_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= regs_d[i];
        end
    end

    // Memory keeps its contents through reset; only the write is blocked.
    always_ff @(posedge clk) begin
        if (!rst && mw) begin
            mem[mem_addr] <= bus_b;
        end
    end

endmodule

// File: tb/tb_cw_datapath.sv
// Scoreboard bench for cw_datapath: a reference model predicts every bus and
// flag per cycle; predictions are queued at drive time and compared mid-cycle.
module tb_cw_datapath;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [54:0] control_word = '0;
    logic [31:0] bus_a, bus_b, bus_d;
    logic        flag_v, flag_c, flag_n, flag_z;

    cw_datapath dut (
        .clk          (clk),
        .rst          (rst),
        .control_word (control_word),
        .bus_a        (bus_a),
        .bus_b        (bus_b),
        .bus_d        (bus_d),
        .flag_v       (flag_v),
        .flag_c       (flag_c),
        .flag_n       (flag_n),
        .flag_z       (flag_z)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic [3:0]  vcnz;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_regs [32];
    logic [31:0] m_mem  [256];
    bit          m_known[256];
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [54:0] mk(input int da, input int aa, input int ba, input bit mb,
                                       input int fs, input bit md, input bit rw, input bit mw,
                                       input logic [31:0] k);
        logic [54:0] cw;
        cw = {da[4:0], aa[4:0], ba[4:0], mb, fs[3:0], md, rw, mw, k};
        return cw;
    endfunction

    // Independent arithmetic: 64-bit sums, overflow from signed range.
    function automatic void fu_model(input logic [31:0] a, input logic [31:0] b, input int fs,
                                     output logic [31:0] f, output bit v, output bit c);
        longint unsigned ua, uy, us;
        longint          sa, sy, ss;
        int              cin;
        f = '0; v = 0; c = 0;
        if (fs < 8) begin
            uy = 0; cin = 0;
            case (fs)
                1: cin = 1;
                2: uy = b;
                3: begin uy = b; cin = 1; end
                4: uy = {32'b0, ~b};
                5: begin uy = {32'b0, ~b}; cin = 1; end
                6: uy = 64'hFFFF_FFFF;
                default: ;
            endcase
            ua = a;
            us = ua + uy + longint'(cin);
            f  = us[31:0];
            c  = us[32];
            sa = longint'($signed(a));
            sy = longint'($signed(uy[31:0]));
            ss = sa + sy + longint'(cin);
            v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        end else begin
            case (fs)
                8:  f = a & b;
                9:  f = a | b;
                10: f = a ^ b;
                11: f = ~a;
                12: f = b;
                13: begin f = b >> 1; c = b[0]; end
                14: begin f = b << 1; c = b[31]; end
                default: begin f = $unsigned($signed(b) >>> 1); c = b[0]; end
            endcase
        end
    endfunction

    // Drive one control word, queue the prediction, leave outputs settling.
    task automatic drive(input bit r, input logic [54:0] cw);
        exp_t        e;
        logic [31:0] f;
        bit          v, c;
        int          fs;
        rst          = r;
        control_word = cw;
        fs  = int'(cw[38:35]);
        e.a = m_regs[cw[49:45]];
        e.b = cw[39] ? cw[31:0] : m_regs[cw[44:40]];
        fu_model(e.a, e.b, fs, f, v, c);
        e.d    = cw[34] ? m_mem[e.a[7:0]] : f;
        e.vcnz = {v, c, f[31], f == 32'h0};
        sb_q.push_back(e);
        #1;
    endtask

    // Compare at the falling edge, then advance the model across the rising edge.
    task automatic retire();
        exp_t        e;
        logic [54:0] cw;
        bit          r;
        @(negedge clk);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        chk("bus_a", bus_a, e.a);
        chk("bus_b", bus_b, e.b);
        chk("bus_d", bus_d, e.d);
        chk("vcnz", {28'b0, flag_v, flag_c, flag_n, flag_z}, {28'b0, e.vcnz});
        cw = control_word;
        r  = rst;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
        end else begin
            if (cw[32]) begin
                m_mem[e.a[7:0]]   = e.b;
                m_known[e.a[7:0]] = 1;
            end
            if (cw[33]) m_regs[cw[54:50]] = e.d;
        end
        #1;
    endtask

    task automatic step(input bit r, input logic [54:0] cw);
        drive(r, cw);
        retire();
    endtask

    initial begin
        logic [54:0] cw;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        for (int i = 0; i < 256; i++) begin m_mem[i] = '0; m_known[i] = 0; end
        @(posedge clk); #1;

        step(1, '0);
        drive(0, mk(0, 1, 2, 0, 4'b0000, 0, 0, 0, 0));
        chk("reset_r1", bus_a, 32'h0);
        retire();

        step(0, mk(1, 0, 0, 1, 4'b1100, 0, 1, 0, 32'd5));
        step(0, mk(2, 0, 0, 1, 4'b1100, 0, 1, 0, 32'd7));

        drive(0, mk(3, 1, 2, 0, 4'b0010, 0, 1, 0, 0));
        chk("add_d", bus_d, 32'd12);
        chk("add_flags", {flag_z, flag_c, flag_v}, 32'd0);
        retire();

        drive(0, mk(0, 1, 2, 0, 4'b0101, 0, 0, 0, 0));
        chk("sub_d", bus_d, 32'hFFFF_FFFE);
        chk("sub_nc", {flag_n, flag_c, flag_v}, 32'b100);
        retire();
        drive(0, mk(0, 2, 1, 0, 4'b0101, 0, 0, 0, 0));
        chk("sub2_d", bus_d, 32'd2);
        chk("sub2_c", flag_c, 32'd1);
        retire();

        step(0, mk(5, 0, 0, 1, 4'b1100, 0, 1, 0, 32'h7FFF_FFFF));
        drive(0, mk(0, 5, 0, 0, 4'b0001, 0, 0, 0, 0));
        chk("inc_d", bus_d, 32'h8000_0000);
        chk("inc_vn", {flag_v, flag_n}, 32'b11);
        retire();
        drive(0, mk(0, 0, 0, 1, 4'b1111, 0, 0, 0, 32'h8000_0001));
        chk("asr_d", bus_d, 32'hC000_0000);
        chk("asr_c", flag_c, 32'd1);
        retire();
        drive(0, mk(0, 0, 0, 1, 4'b1101, 0, 0, 0, 32'h8000_0001));
        chk("lsr_d", bus_d, 32'h4000_0000);
        retire();

        step(0, mk(0, 1, 3, 0, 4'b0000, 0, 0, 1, 0));
        drive(0, mk(6, 1, 0, 0, 4'b0000, 1, 1, 0, 0));
        chk("mem_rd", bus_d, 32'd12);
        retire();
        step(0, mk(0, 0, 0, 1, 4'b1100, 0, 1, 0, 32'h105));
        drive(0, mk(0, 0, 0, 0, 4'b0000, 1, 0, 0, 0));
        chk("mem_wrap", bus_d, 32'd12);
        retire();

        drive(0, mk(1, 1, 0, 1, 4'b1100, 0, 1, 0, 32'h55));
        chk("rdw_old", bus_a, 32'd5);
        retire();

        step(1, mk(1, 0, 0, 1, 4'b1100, 0, 1, 0, 32'd9));
        drive(0, mk(2, 1, 0, 1, 4'b1100, 0, 1, 0, 32'd5));
        chk("rst_r1", bus_a, 32'h0);
        retire();
        drive(0, mk(0, 2, 0, 0, 4'b0000, 1, 0, 0, 0));
        chk("mem_kept", bus_d, 32'd12);
        retire();

        for (int n = 0; n < 300; n++) begin
            cw = {$urandom, $urandom};
            if (cw[34] && !m_known[m_regs[cw[49:45]][7:0]]) cw[34] = 0;
            step(($urandom_range(0, 39) == 0), cw);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
